// File: rtl/cla_adder_16b.sv
// cla_adder_16b: 16-bit two-level carry-lookahead adder with registered outputs.
// {CO,S} = A + B + CI, one cycle of latency, one operation per cycle.
// Bit-level generate/propagate feeds GROUP_W-bit lookahead groups; a second-level
// lookahead unit (LCU) computes every group carry-in directly from CI.
// Optional feature: define CLA_OVF_EN to add the registered signed-overflow
// output OVF (= c16 ^ c15).
module cla_adder_16b #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
`ifdef CLA_OVF_EN
    output logic             OVF,
`endif
    output logic             CO
);

    localparam int unsigned N_GROUPS = (GROUP_W == 0) ? 1 : WIDTH / GROUP_W;
    localparam int unsigned LA_W     = (GROUP_W > N_GROUPS) ? GROUP_W : N_GROUPS;

    // Reject unsupported configurations at elaboration time
    generate
        if (WIDTH != 16) begin : g_bad_width
            $error("cla_adder_16b: WIDTH must be 16");
        end
        if (GROUP_W == 0 || (WIDTH % GROUP_W) != 0) begin : g_bad_group
            $error("cla_adder_16b: GROUP_W must divide WIDTH");
        end
    endgenerate

    // Flat lookahead carry out of position n-1: OR over k of g[k] & p[k+1..n-1],
    // plus cin & p[0..n-1]. Every term is a single product, so no ripple.
    function automatic logic lookahead(
        input logic [LA_W-1:0] gv,
        input logic [LA_W-1:0] pv,
        input logic            cin,
        input int unsigned     n
    );
        logic carry;
        logic term;
        carry = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            term = gv[k];
            for (int unsigned m = k + 1; m < n; m++) begin
                term = term & pv[m];
            end
            carry = carry | term;
        end
        term = cin;
        for (int unsigned m = 0; m < n; m++) begin
            term = term & pv[m];
        end
        carry = carry | term;
        return carry;
    endfunction

    logic [WIDTH-1:0]    p;
    logic [WIDTH-1:0]    g;
    logic [WIDTH:0]      c;
    logic [N_GROUPS-1:0] grp_p;
    logic [N_GROUPS-1:0] grp_g;
    logic [N_GROUPS:0]   grp_c;
    logic [WIDTH-1:0]    sum_c;

    // Bit-level propagate and generate
    assign p = A ^ B;
    assign g = A & B;

    // First level: group PG/GG and in-group carries from the group carry-in
    generate
        for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_group
            localparam int unsigned BASE = gi * GROUP_W;

            assign grp_p[gi] = &p[BASE +: GROUP_W];
            assign grp_g[gi] = lookahead(LA_W'(g[BASE +: GROUP_W]),
                                         LA_W'(p[BASE +: GROUP_W]),
                                         1'b0, GROUP_W);
            assign c[BASE]   = grp_c[gi];

            for (genvar j = 1; j < GROUP_W; j++) begin : g_bit_carry
                assign c[BASE + j] = lookahead(LA_W'(g[BASE +: GROUP_W]),
                                               LA_W'(p[BASE +: GROUP_W]),
                                               grp_c[gi], j);
            end
        end
    endgenerate

    // Second level: LCU derives each group carry-in straight from CI
    assign grp_c[0] = CI;
    generate
        for (genvar i = 1; i <= N_GROUPS; i++) begin : g_lcu
            assign grp_c[i] = lookahead(LA_W'(grp_g), LA_W'(grp_p), CI, i);
        end
    endgenerate

    assign c[WIDTH] = grp_c[N_GROUPS];
    assign sum_c    = p ^ c[WIDTH-1:0];

    // Output register: capture on in_valid, hold otherwise; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            CO        <= 1'b0;
`ifdef CLA_OVF_EN
            OVF       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S   <= sum_c;
                CO  <= c[WIDTH];
`ifdef CLA_OVF_EN
                OVF <= c[WIDTH] ^ c[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_16b.sv
// Self-checking bench for cla_adder_16b against an arithmetic reference model.
// Build with +define+CLA_OVF_EN to also check the OVF output.
module tb_cla_adder_16b;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        out_valid;
    logic [15:0] s;
    logic        co;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif

    int checks;
    int failures;

    cla_adder_16b dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (a),
        .B        (b),
        .CI       (ci),
        .out_valid(out_valid),
        .S        (s),
`ifdef CLA_OVF_EN
        .OVF      (ovf),
`endif
        .CO       (co)
    );

    always #5 clk = ~clk;

    // Reference: plain 17-bit unsigned sum and signed-range overflow test
    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic cin);
        return 17'(x) + 17'(y) + 17'(cin);
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                     input logic cin);
        int r;
        r = int'($signed(x)) + int'($signed(y)) + int'(cin);
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'd5; b = 16'd5; ci = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (s !== 16'd0 || co !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: got S=%h CO=%b V=%b want S=0 CO=0 V=0",
                         i, s, co, out_valid);
            end
`ifdef CLA_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_ovf: got %b want 0", ovf);
            end
`endif
        end
        rst = 1'b0;
        step();
        checks++;
        if (s !== 16'd10 || co !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got S=%0d CO=%b V=%b want S=10 CO=0 V=1",
                     s, co, out_valid);
        end
    endtask

    task automatic test_small_sums();
        logic [15:0] ta[8] = '{16'd0, 16'd1, 16'd1, 16'd0, 16'd54, 16'd200, 16'd444, 16'd444};
        logic [15:0] tb[8] = '{16'd0, 16'd1, 16'd1, 16'd0, 16'd46, 16'd100, 16'd666, 16'd666};
        logic        tc[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] ts[8] = '{16'd0, 16'd2, 16'd3, 16'd1, 16'd100, 16'd301, 16'd1110, 16'd1111};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = ta[i]; b = tb[i]; ci = tc[i];
            step();
            checks++;
            if (s !== ts[i] || co !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL small_sum[%0d]: got S=%0d CO=%b V=%b want S=%0d CO=0 V=1",
                         i, s, co, out_valid, ts[i]);
            end
        end
    endtask

    // Directed vectors with hand-computed S/CO/OVF
    task automatic test_boundaries();
        logic [15:0] va[6] = '{16'h7FFF, 16'h7FFF, 16'd30000, 16'hFFFF, 16'h8000, 16'h0FFF};
        logic [15:0] vb[6] = '{16'h7FFF, 16'h7FFF, 16'd2767,  16'h0000, 16'h8000, 16'h0001};
        logic        vc[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] vs[6] = '{16'hFFFF, 16'hFFFE, 16'd32767, 16'h0000, 16'h0000, 16'h1000};
        logic        vo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        vf[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; ci = vc[i];
            step();
            checks++;
            if (s !== vs[i] || co !== vo[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL boundary[%0d]: got S=%h CO=%b V=%b want S=%h CO=%b V=1",
                         i, s, co, out_valid, vs[i], vo[i]);
            end
`ifdef CLA_OVF_EN
            checks++;
            if (ovf !== vf[i]) begin
                failures++;
                $display("FAIL boundary_ovf[%0d]: got %b want %b", i, ovf, vf[i]);
            end
`else
            if (vf[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a = 16'd444; b = 16'd666; ci = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            step();
            checks++;
            if (s !== 16'd1110 || co !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: got S=%0d CO=%b V=%b want S=1110 CO=0 V=0",
                         i, s, co, out_valid);
            end
        end
    endtask

    // Random operands and random in_valid; model holds the last captured result
    task automatic test_random();
        logic [16:0] exp_sum;
        logic        exp_ovf;
        logic        exp_v;
        exp_sum = ref_sum(16'd444, 16'd666, 1'b0);
        exp_ovf = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            if (i % 16 == 0) a = 16'hFFFF - b;
            exp_v = in_valid;
            if (in_valid) begin
                exp_sum = ref_sum(a, b, ci);
                exp_ovf = ref_ovf(a, b, ci);
            end
            step();
            checks++;
            if ({co, s} !== exp_sum || out_valid !== exp_v) begin
                failures++;
                $display("FAIL random[%0d]: got CO:S=%h V=%b want CO:S=%h V=%b",
                         i, {co, s}, out_valid, exp_sum, exp_v);
            end
`ifdef CLA_OVF_EN
            checks++;
            if (ovf !== exp_ovf) begin
                failures++;
                $display("FAIL random_ovf[%0d]: got %b want %b", i, ovf, exp_ovf);
            end
`endif
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
        checks = 0; failures = 0;
        test_reset();
        test_small_sums();
        test_boundaries();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
